ulaw_argmax_unit: RTL and testbench

Sequential argmax and accuracy unit for the MNIST inference engine's output layer. It latches a vector of `N_CLASSES` class scores when `start` is pulsed and scans them one per cycle. It reports the 1-based index of the strictly largest score and compares that index against the expected label. It replaces the bench-side argmax loop with synthesisable hardware; the scores are either μ-law codes or two's-complement values.

---
 rtl/ulaw_argmax_unit_if.sv | 32 +++
 rtl/ulaw_argmax_unit.sv | 211 +++++++++++++++++++++
 tb/tb_ulaw_argmax_unit.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ulaw_argmax_unit_if.sv
// ulaw_argmax_unit_if: control, score and result bundle for ulaw_argmax_unit.
// The master drives start/clear/scores/exp_label; the slave (the unit) returns
// scan status, the winning index/code, and the hit statistics.
interface ulaw_argmax_unit_if #(
    parameter int N_CLASSES  = 10,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    localparam int IDX_W = $clog2(N_CLASSES + 1);

    logic                            start;
    logic                            clear;
    logic [N_CLASSES*DATA_WIDTH-1:0] scores;
    logic [IDX_W-1:0]                exp_label;
    logic                            busy;
    logic                            done;
    logic [IDX_W-1:0]                max_idx;
    logic [DATA_WIDTH-1:0]           max_code;
    logic                            hit;
    logic [CNT_WIDTH-1:0]            hit_cnt;
    logic [CNT_WIDTH-1:0]            tc_cnt;

    modport master (
        output start, clear, scores, exp_label,
        input  busy, done, max_idx, max_code, hit, hit_cnt, tc_cnt
    );

    modport slave (
        input  start, clear, scores, exp_label,
        output busy, done, max_idx, max_code, hit, hit_cnt, tc_cnt
    );
endinterface

// File: rtl/ulaw_argmax_unit.sv
// ulaw_argmax_unit: sequential argmax over N_CLASSES scores (one per cycle),
// reporting the 1-based index of the strictly largest score and whether it
// matches the expected label. Scores are u-law codes (MODE=0, stored inverted)
// or signed two's complement (MODE=1).
// Optional build macro ULAW_ARGMAX_STATS_EN: when defined, saturating hit and
// test-case counters are built; otherwise hit_cnt/tc_cnt are tied to zero.
module ulaw_argmax_unit #(
    parameter int N_CLASSES  = 10,
    parameter int DATA_WIDTH = 8,
    parameter int MODE       = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    ulaw_argmax_unit_if.slave bus
);
    localparam int IDX_W   = $clog2(N_CLASSES + 1);
    localparam int SCORE_W = N_CLASSES * DATA_WIDTH;
    localparam int KEY_W   = DATA_WIDTH + 1;

    // Lowest possible key: nothing strictly beats it, so an all-floor vector
    // leaves max_idx at 0.
    localparam logic [DATA_WIDTH-1:0] FLOOR_CODE =
        (MODE == 0) ? '0 : {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0] LAST_ELEM = IDX_W'(N_CLASSES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Map a raw code onto a signed key whose natural order is the score order.
    // u-law: undo the storage inversion, then put positives above negatives
    // and reverse the magnitude order of the negatives.
    function automatic logic signed [KEY_W-1:0] score_key(input logic [DATA_WIDTH-1:0] code);
        logic [7:0] inv;
        logic [7:0] ukey;
        inv  = ~8'(code);
        ukey = inv[7] ? {1'b0, ~inv[6:0]} : {1'b1, inv[6:0]};
        if (MODE == 0) begin
            score_key = $signed(KEY_W'(ukey));
        end else begin
            score_key = $signed({code[DATA_WIDTH-1], code});
        end
    endfunction

    state_t                  state_q, state_d;
    logic [SCORE_W-1:0]      shadow_q, shadow_d;
    logic [IDX_W-1:0]        exp_q, exp_d;
    logic [IDX_W-1:0]        elem_q, elem_d;
    logic [DATA_WIDTH-1:0]   best_q, best_d;
    logic [IDX_W-1:0]        max_idx_q, max_idx_d;
    logic [DATA_WIDTH-1:0]   max_code_q, max_code_d;
    logic                    hit_q, hit_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [DATA_WIDTH-1:0]   cur_code;
    logic [IDX_W-1:0]        cand_idx;
    logic [IDX_W-1:0]        final_idx;
    logic                    win;

    // The shadow register shifts down one score per cycle, so the element
    // under test is always in the low slot.
    assign cur_code  = shadow_q[DATA_WIDTH-1:0];
    assign cand_idx  = elem_q + IDX_W'(1);
    assign win       = score_key(cur_code) > score_key(best_q);
    assign final_idx = win ? cand_idx : max_idx_q;

    // Next-state logic for the scan FSM and its registered outputs.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        exp_d      = exp_q;
        elem_d     = elem_q;
        best_d     = best_q;
        max_idx_d  = max_idx_q;
        max_code_d = max_code_q;
        hit_d      = hit_q;
        busy_d     = busy_q;
        done_d     = done_q;

        if (bus.clear) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_d    = S_SCAN;
                        shadow_d   = bus.scores;
                        exp_d      = bus.exp_label;
                        elem_d     = '0;
                        best_d     = FLOOR_CODE;
                        max_idx_d  = '0;
                        max_code_d = FLOOR_CODE;
                        busy_d     = 1'b1;
                        done_d     = 1'b0;
                    end
                end
                S_SCAN: begin
                    shadow_d = shadow_q >> DATA_WIDTH;
                    elem_d   = cand_idx;
                    if (win) begin
                        best_d     = cur_code;
                        max_idx_d  = cand_idx;
                        max_code_d = cur_code;
                    end
                    if (elem_q == LAST_ELEM) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        hit_d   = (final_idx == exp_q);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // Control and output registers; reset puts the best register at the floor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            elem_q     <= '0;
            best_q     <= FLOOR_CODE;
            max_idx_q  <= '0;
            max_code_q <= '0;
            hit_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            elem_q     <= elem_d;
            best_q     <= best_d;
            max_idx_q  <= max_idx_d;
            max_code_q <= max_code_d;
            hit_q      <= hit_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Latched scores and label are pure data and are always reloaded on start.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
        exp_q    <= exp_d;
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.max_idx  = max_idx_q;
    assign bus.max_code = max_code_q;
    assign bus.hit      = hit_q;

`ifdef ULAW_ARGMAX_STATS_EN
    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v != '1) begin
            sat_inc = v + CNT_WIDTH'(1);
        end else begin
            sat_inc = v;
        end
    endfunction

    logic                 scan_end;
    logic [CNT_WIDTH-1:0] tc_cnt_q, tc_cnt_d;
    logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;

    assign scan_end = (state_q == S_SCAN) && (elem_q == LAST_ELEM) && !bus.clear;

    // Statistics next state: clear wins, otherwise count on scan completion.
    always_comb begin
        tc_cnt_d  = tc_cnt_q;
        hit_cnt_d = hit_cnt_q;
        if (bus.clear) begin
            tc_cnt_d  = '0;
            hit_cnt_d = '0;
        end else if (scan_end) begin
            tc_cnt_d = sat_inc(tc_cnt_q);
            if (hit_d) begin
                hit_cnt_d = sat_inc(hit_cnt_q);
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc_cnt_q  <= '0;
            hit_cnt_q <= '0;
        end else begin
            tc_cnt_q  <= tc_cnt_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign bus.tc_cnt  = tc_cnt_q;
    assign bus.hit_cnt = hit_cnt_q;
`else
    assign bus.tc_cnt  = '0;
    assign bus.hit_cnt = '0;
`endif

endmodule

// File: tb/tb_ulaw_argmax_unit.sv
// tb_ulaw_argmax_unit: directed and random checks of ulaw_argmax_unit.
// Unit A: MODE=0 (u-law), CNT_WIDTH=16. Unit B: MODE=1 (signed), CNT_WIDTH=4.
// A behavioural argmax model predicts every result; a negedge checker compares
// status, results and counters each cycle, plus literal spot checks.
module tb_ulaw_argmax_unit;
    localparam int N  = 10;
    localparam int DW = 8;
    localparam int IW = $clog2(N + 1);
    localparam int SW = N * DW;

`ifdef ULAW_ARGMAX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start_v  [2];
    logic          clear_v  [2];
    logic [SW-1:0] scores_v [2];
    logic [IW-1:0] label_v  [2];

    ulaw_argmax_unit_if #(.N_CLASSES(N), .DATA_WIDTH(DW), .CNT_WIDTH(16)) ifa ();
    ulaw_argmax_unit_if #(.N_CLASSES(N), .DATA_WIDTH(DW), .CNT_WIDTH(4))  ifb ();

    assign ifa.start     = start_v[0];
    assign ifa.clear     = clear_v[0];
    assign ifa.scores    = scores_v[0];
    assign ifa.exp_label = label_v[0];
    assign ifb.start     = start_v[1];
    assign ifb.clear     = clear_v[1];
    assign ifb.scores    = scores_v[1];
    assign ifb.exp_label = label_v[1];

    ulaw_argmax_unit #(.N_CLASSES(N), .DATA_WIDTH(DW), .MODE(0), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    ulaw_argmax_unit #(.N_CLASSES(N), .DATA_WIDTH(DW), .MODE(1), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    logic       e_busy [2];
    logic       e_done [2];
    logic       chk_res[2];
    logic       e_hit  [2];
    int         e_idx  [2];
    logic [7:0] e_code [2];
    int         tc_m   [2];
    int         hc_m   [2];

    task automatic check(input string name, input longint act, input longint req);
        total_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    // Score order from the encoding itself: u-law is sign/magnitude with
    // +0 just above -0, so map to 2*mag+1 (positive) or -2*mag (negative).
    function automatic int key_of(input logic [7:0] c, input int mode);
        logic [7:0] m;
        int mag;
        if (mode == 1) return int'($signed(c));
        m   = ~c;
        mag = int'(m[6:0]);
        return m[7] ? -2 * mag : 2 * mag + 1;
    endfunction

    function automatic void model(input logic [SW-1:0] s, input int mode,
                                  output int idx, output logic [7:0] code);
        int best;
        logic [7:0] b;
        code = (mode == 1) ? 8'h80 : 8'h00;
        best = key_of(code, mode);
        idx  = 0;
        for (int i = 0; i < N; i++) begin
            b = s[i*8 +: 8];
            if (key_of(b, mode) > best) begin
                best = key_of(b, mode);
                idx  = i + 1;
                code = b;
            end
        end
    endfunction

    function automatic logic [SW-1:0] fill(input logic [7:0] b);
        logic [SW-1:0] v;
        for (int i = 0; i < N; i++) v[i*8 +: 8] = b;
        return v;
    endfunction

    function automatic logic [SW-1:0] rand_vec();
        logic [SW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) v[i*8 +: 8] = v[(i-1)*8 +: 8];
            else v[i*8 +: 8] = 8'($urandom);
        end
        return v;
    endfunction

    task automatic check_dut(input int d, input logic busy, input logic done,
                             input logic [IW-1:0] idx, input logic [7:0] code,
                             input logic hit, input int hc, input int tc);
        string p;
        int lim, etc, ehc;
        p   = (d == 0) ? "a" : "b";
        lim = (d == 0) ? 65535 : 15;
        etc = STATS ? ((tc_m[d] > lim) ? lim : tc_m[d]) : 0;
        ehc = STATS ? ((hc_m[d] > lim) ? lim : hc_m[d]) : 0;
        check({p, "_busy"}, busy, e_busy[d]);
        check({p, "_done"}, done, e_done[d]);
        check({p, "_tc_cnt"}, tc, etc);
        check({p, "_hit_cnt"}, hc, ehc);
        if (chk_res[d]) begin
            check({p, "_max_idx"}, idx, e_idx[d]);
            check({p, "_max_code"}, code, e_code[d]);
            check({p, "_hit"}, hit, e_hit[d]);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_dut(0, ifa.busy, ifa.done, ifa.max_idx, ifa.max_code, ifa.hit,
                      int'(ifa.hit_cnt), int'(ifa.tc_cnt));
            check_dut(1, ifb.busy, ifb.done, ifb.max_idx, ifb.max_code, ifb.hit,
                      int'(ifb.hit_cnt), int'(ifb.tc_cnt));
        end
    end

    // All driver tasks begin and end 1 time unit after a rising edge.
    task automatic start_case(input int d, input logic [SW-1:0] s, input logic [IW-1:0] lab);
        scores_v[d] = s;
        label_v[d]  = lab;
        start_v[d]  = 1'b1;
        @(posedge clk); #1;
        start_v[d]  = 1'b0;
        scores_v[d] = rand_vec();
        label_v[d]  = IW'($urandom_range(0, N));
        e_busy[d]   = 1'b1;
        e_done[d]   = 1'b0;
        chk_res[d]  = 1'b0;
    endtask

    task automatic finish_case(input int d, input logic [SW-1:0] s, input logic [IW-1:0] lab,
                               input int edges_done);
        int idx;
        logic [7:0] code;
        repeat (N - edges_done) @(posedge clk);
        #1;
        model(s, d, idx, code);
        e_idx[d]   = idx;
        e_code[d]  = code;
        e_hit[d]   = (idx == int'(lab));
        tc_m[d]++;
        if (e_hit[d]) hc_m[d]++;
        e_busy[d]  = 1'b0;
        e_done[d]  = 1'b1;
        chk_res[d] = 1'b1;
    endtask

    task automatic run_case(input int d, input logic [SW-1:0] s, input logic [IW-1:0] lab);
        start_case(d, s, lab);
        finish_case(d, s, lab, 0);
    endtask

    task automatic do_clear(input int d, input logic with_start, input logic [SW-1:0] s);
        clear_v[d]  = 1'b1;
        start_v[d]  = with_start;
        scores_v[d] = s;
        @(posedge clk); #1;
        clear_v[d]  = 1'b0;
        start_v[d]  = 1'b0;
        e_busy[d]   = 1'b0;
        e_done[d]   = 1'b0;
        chk_res[d]  = 1'b0;
        tc_m[d]     = 0;
        hc_m[d]     = 0;
    endtask

    initial begin
        logic [SW-1:0] s, t1;
        int idx, lab;
        logic [7:0] code;

        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0; clear_v[d] = 1'b0; scores_v[d] = '0; label_v[d] = '0;
            e_busy[d] = 1'b0; e_done[d] = 1'b0; chk_res[d] = 1'b1; e_hit[d] = 1'b0;
            e_idx[d] = 0; e_code[d] = 8'h00; tc_m[d] = 0; hc_m[d] = 0;
        end
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("reset_b_max_code", ifb.max_code, 0);
        check("reset_a_done", ifa.done, 0);

        // Single scan: only score[6] is a non-zero positive
        t1 = fill(8'hFF); t1[6*8 +: 8] = 8'hA0;
        run_case(0, t1, 4'd7);
        check("t1_max_idx", ifa.max_idx, 7);
        check("t1_max_code", ifa.max_code, 8'hA0);
        check("t1_hit", ifa.hit, 1);
        check("t1_hit_cnt", ifa.hit_cnt, STATS ? 1 : 0);
        check("t1_tc_cnt", ifa.tc_cnt, STATS ? 1 : 0);
        repeat (3) @(posedge clk);
        #1;

        // Ties keep the earlier index; -0 loses to +0.9x; large negatives lose
        s = fill(8'h10); s[0 +: 8] = 8'h7F; s[2*8 +: 8] = 8'h90; s[5*8 +: 8] = 8'h90;
        run_case(0, s, 4'd3);
        check("tie_max_idx", ifa.max_idx, 3);
        check("tie_max_code", ifa.max_code, 8'h90);
        run_case(0, fill(8'h00), 4'd5);
        check("floor_max_idx", ifa.max_idx, 0);
        check("floor_max_code", ifa.max_code, 8'h00);
        check("floor_hit", ifa.hit, 0);

        // start during SCAN is ignored, as are input changes after the start edge
        s = fill(8'hFF); s[1*8 +: 8] = 8'hC0;
        start_case(0, s, 4'd2);
        repeat (2) @(posedge clk);
        #1;
        start_v[0] = 1'b1; scores_v[0] = fill(8'h80);
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        finish_case(0, s, 4'd2, 3);
        check("restart_max_idx", ifa.max_idx, 2);
        check("restart_done", ifa.done, 1);

        // clear mid-scan aborts and zeroes the statistics
        start_case(0, rand_vec(), 4'd1);
        repeat (3) @(posedge clk);
        #1;
        do_clear(0, 1'b0, rand_vec());
        check("abort_busy", ifa.busy, 0);
        check("abort_tc_cnt", ifa.tc_cnt, 0);
        repeat (2) @(posedge clk);
        #1;

        // clear and start on the same edge: clear wins, no scan starts
        run_case(0, t1, 4'd7);
        do_clear(0, 1'b1, fill(8'h80));
        check("clrstart_done", ifa.done, 0);
        check("clrstart_busy", ifa.busy, 0);
        check("clrstart_tc_cnt", ifa.tc_cnt, 0);
        check("clrstart_hit_cnt", ifa.hit_cnt, 0);
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back random stress on the u-law unit
        for (int k = 0; k < 5000; k++) begin
            s = rand_vec();
            model(s, 0, idx, code);
            lab = ($urandom_range(0, 1) == 0) ? idx : int'($urandom_range(0, N));
            run_case(0, s, IW'(lab));
        end
        check("stress_tc_cnt", ifa.tc_cnt, STATS ? 5000 : 0);
        check("stress_hit_cnt", ifa.hit_cnt, STATS ? hc_m[0] : 0);

        // Two's complement: {-5, 3, 3, -128, -1 ...}
        s = fill(8'hFF); s[0 +: 8] = 8'hFB; s[1*8 +: 8] = 8'h03; s[2*8 +: 8] = 8'h03; s[3*8 +: 8] = 8'h80;
        run_case(1, s, 4'd2);
        check("s2c_max_idx", ifb.max_idx, 2);
        check("s2c_max_code", ifb.max_code, 8'h03);
        check("s2c_hit_cnt", ifb.hit_cnt, STATS ? 1 : 0);
        run_case(1, s, 4'd4);
        check("s2c_miss_hit", ifb.hit, 0);
        check("s2c_miss_hit_cnt", ifb.hit_cnt, STATS ? 1 : 0);
        run_case(1, fill(8'h80), 4'd0);
        check("s2c_floor_idx", ifb.max_idx, 0);
        check("s2c_floor_code", ifb.max_code, 8'h80);
        for (int k = 0; k < 20; k++) run_case(1, rand_vec(), IW'($urandom_range(0, N)));
        check("sat_tc_cnt", ifb.tc_cnt, STATS ? 15 : 0);

        // Asynchronous reset in the middle of a scan
        start_case(0, rand_vec(), 4'd3);
        repeat (3) @(posedge clk);
        #3;
        for (int d = 0; d < 2; d++) begin
            e_busy[d] = 1'b0; e_done[d] = 1'b0; chk_res[d] = 1'b1; e_hit[d] = 1'b0;
            e_idx[d] = 0; e_code[d] = 8'h00; tc_m[d] = 0; hc_m[d] = 0;
        end
        rst = 1'b1;
        #1;
        check("arst_busy", ifa.busy, 0);
        check("arst_max_idx", ifa.max_idx, 0);
        check("arst_max_code", ifa.max_code, 0);
        check("arst_tc_cnt", ifa.tc_cnt, 0);
        check("arst_b_tc_cnt", ifb.tc_cnt, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        run_case(0, t1, 4'd7);
        check("recover_max_idx", ifa.max_idx, 7);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
